// File: rtl/mine_game_ctrl.sv
// mine_game_ctrl: board state and game-flow controller for the minesweeper design.
// This block keeps the mine, revealed and flagged bitmaps for a ROWS x COLS board.
// It places MINES mines at run time from a 16-bit Fibonacci LFSR.
// Reveal and flag commands arrive over a valid/ready handshake.
// The block also tracks the reveal count, flag count and elapsed seconds.
// Optional feature macro: FIRST_CLICK_SAFE_EN. When it is defined, mine placement
// waits for the first reveal and never puts a mine under that cell.
module mine_game_ctrl #(
   parameter int ROWS   = 8,
   parameter int COLS   = 8,
   parameter int MINES  = 10,
   parameter int CLK_HZ = 25000000,
   parameter int TIME_W = 10,
   localparam int N     = ROWS * COLS,
   localparam int IW    = $clog2(N),
   localparam int CW    = $clog2(N + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [15:0]       seed,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [IW-1:0]     cmd_idx,
   output logic [N-1:0]      mine_map,
   output logic [N-1:0]      revealed,
   output logic [N-1:0]      flagged,
   output logic [CW-1:0]     reveal_count,
   output logic [CW-1:0]     flag_count,
   output logic [TIME_W-1:0] seconds,
   output logic              placing,
   output logic              endgame,
   output logic              win
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARMED   = 3'd1;
   localparam logic [2:0] S_PLACE   = 3'd2;
   localparam logic [2:0] S_PLAYING = 3'd3;
   localparam logic [2:0] S_LOST    = 3'd4;
   localparam logic [2:0] S_WON     = 3'd5;

   localparam int              PW           = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]   PRESC_MAX    = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0]   PRESC_ONE    = PW'(1);
   localparam logic [IW:0]     N_LIM        = (IW + 1)'(N);
   localparam logic [CW-1:0]   CNT_ONE      = CW'(1);
   localparam logic [CW-1:0]   MINES_V      = CW'(MINES);
   localparam logic [CW-1:0]   SAFE_V       = CW'(N - MINES);
   localparam logic [TIME_W-1:0] SEC_ONE    = TIME_W'(1);
   localparam logic [TIME_W-1:0] SEC_MAX    = {TIME_W{1'b1}};
   localparam logic [15:0]     LFSR_DEFAULT = 16'hACE1;

`ifdef FIRST_CLICK_SAFE_EN
   localparam bit FIRST_SAFE = 1'b1;
`else
   localparam bit FIRST_SAFE = 1'b0;
`endif

   // Reject parameter sets that cannot describe a playable board
   if (ROWS < 2 || ROWS > 32 || COLS < 2 || COLS > 32) begin : gBadDims
      $error("mine_game_ctrl: ROWS and COLS must lie in 2..32");
   end
   if (MINES < 1 || MINES > N - 2) begin : gBadMines
      $error("mine_game_ctrl: MINES must lie in 1..ROWS*COLS-2");
   end
   if (CLK_HZ < 1 || TIME_W < 1) begin : gBadTimer
      $error("mine_game_ctrl: CLK_HZ and TIME_W must be positive");
   end

   logic [2:0]        state_q, state_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [N-1:0]      mine_q, mine_d;
   logic [N-1:0]      rev_q, rev_d;
   logic [N-1:0]      flag_q, flag_d;
   logic [CW-1:0]     revCnt_q, revCnt_d;
   logic [CW-1:0]     flagCnt_q, flagCnt_d;
   logic [CW-1:0]     placed_q, placed_d;
   logic [IW-1:0]     excl_q, excl_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [TIME_W-1:0] sec_q, sec_d;

   logic          lfsrFb;
   logic [IW-1:0] cand;
   logic          candOk;
   logic          cmdFire;
   logic          idxOk;

   // The taps for x^16+x^14+x^13+x^11+1 land on bits 0,2,3,5 in a right-shifting register.
   // A placement candidate is the low IW bits of the current LFSR value.
   // The excluded cell only exists once the first-click-safe feature has captured it.
   always_comb begin
      lfsrFb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
      cand    = lfsr_q[IW-1:0];
      candOk  = ({1'b0, cand} < N_LIM) && !mine_q[cand] && !(FIRST_SAFE && (cand == excl_q));
      cmdFire = cmd_valid && cmd_ready;
      idxOk   = ({1'b0, cmd_idx} < N_LIM);
   end

   // Next-state logic. start wins over everything except rst.
   // PLACE tries one candidate per cycle.
   // PLAYING runs the timer and applies one command per accepted handshake.
   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      mine_d    = mine_q;
      rev_d     = rev_q;
      flag_d    = flag_q;
      revCnt_d  = revCnt_q;
      flagCnt_d = flagCnt_q;
      placed_d  = placed_q;
      excl_d    = excl_q;
      presc_d   = presc_q;
      sec_d     = sec_q;

      if (start) begin
         state_d   = FIRST_SAFE ? S_ARMED : S_PLACE;
         lfsr_d    = (seed == 16'h0000) ? LFSR_DEFAULT : seed;
         mine_d    = '0;
         rev_d     = '0;
         flag_d    = '0;
         revCnt_d  = '0;
         flagCnt_d = '0;
         placed_d  = '0;
         excl_d    = '0;
         presc_d   = '0;
         sec_d     = '0;
      end else begin
         case (state_q)
            S_ARMED: begin
               if (cmdFire && !cmd_op && idxOk) begin
                  excl_d  = cmd_idx;
                  state_d = S_PLACE;
               end
            end
            S_PLACE: begin
               lfsr_d = {lfsrFb, lfsr_q[15:1]};
               if (candOk) begin
                  mine_d[cand] = 1'b1;
                  placed_d     = placed_q + CNT_ONE;
                  if (placed_q + CNT_ONE == MINES_V) begin
                     state_d = S_PLAYING;
                     if (FIRST_SAFE) begin
                        rev_d[excl_q] = 1'b1;
                        revCnt_d      = CNT_ONE;
                     end
                  end
               end
            end
            S_PLAYING: begin
               if (presc_q == PRESC_MAX) begin
                  presc_d = '0;
                  if (sec_q != SEC_MAX) begin
                     sec_d = sec_q + SEC_ONE;
                  end
               end else begin
                  presc_d = presc_q + PRESC_ONE;
               end
               if (cmdFire && idxOk) begin
                  if (!cmd_op) begin
                     if (!flag_q[cmd_idx] && !rev_q[cmd_idx]) begin
                        rev_d[cmd_idx] = 1'b1;
                        if (mine_q[cmd_idx]) begin
                           state_d = S_LOST;
                        end else begin
                           revCnt_d = revCnt_q + CNT_ONE;
                           if (revCnt_q + CNT_ONE == SAFE_V) begin
                              state_d = S_WON;
                           end
                        end
                     end
                  end else if (!rev_q[cmd_idx]) begin
                     flag_d[cmd_idx] = !flag_q[cmd_idx];
                     flagCnt_d       = flag_q[cmd_idx] ? (flagCnt_q - CNT_ONE) : (flagCnt_q + CNT_ONE);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // State registers. Reset returns to IDLE with clear maps and the default LFSR value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         lfsr_q    <= LFSR_DEFAULT;
         mine_q    <= '0;
         rev_q     <= '0;
         flag_q    <= '0;
         revCnt_q  <= '0;
         flagCnt_q <= '0;
         placed_q  <= '0;
         excl_q    <= '0;
         presc_q   <= '0;
         sec_q     <= '0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         mine_q    <= mine_d;
         rev_q     <= rev_d;
         flag_q    <= flag_d;
         revCnt_q  <= revCnt_d;
         flagCnt_q <= flagCnt_d;
         placed_q  <= placed_d;
         excl_q    <= excl_d;
         presc_q   <= presc_d;
         sec_q     <= sec_d;
      end
   end

   // Every output is either a register or a decode of the registered state.
   always_comb begin
      mine_map     = mine_q;
      revealed     = rev_q;
      flagged      = flag_q;
      reveal_count = revCnt_q;
      flag_count   = flagCnt_q;
      seconds      = sec_q;
      placing      = (state_q == S_PLACE);
      endgame      = (state_q == S_LOST) || (state_q == S_WON);
      win          = (state_q == S_WON);
      cmd_ready    = (state_q == S_ARMED) || (state_q == S_PLAYING);
   end

endmodule

// File: tb/tb_mine_game_ctrl.sv
// tb_mine_game_ctrl: self-checking bench for mine_game_ctrl on an 8x8 board with 10 mines.
// The bench uses a fast timer (CLK_HZ=4, TIME_W=3).
// A behavioural game model predicts mine placement, bitmaps, counters, timer and end state.
// The model also follows FIRST_CLICK_SAFE_EN when that macro is defined.
module tb_mine_game_ctrl;

   localparam int ROWS   = 8;
   localparam int COLS   = 8;
   localparam int MINES  = 10;
   localparam int CLK_HZ = 4;
   localparam int TIME_W = 3;
   localparam int N      = ROWS * COLS;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] seed;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_op;
   logic [5:0]  cmd_idx;
   logic [63:0] mine_map;
   logic [63:0] revealed;
   logic [63:0] flagged;
   logic [6:0]  reveal_count;
   logic [6:0]  flag_count;
   logic [2:0]  seconds;
   logic        placing;
   logic        endgame;
   logic        win;

   int checks   = 0;
   int failures = 0;

   logic [63:0] mMine, mRev, mFlag;
   int          mRevCnt, mFlagCnt, playEdges;
   bit          mPlaying, mLost, mWon;

   mine_game_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .MINES(MINES), .CLK_HZ(CLK_HZ), .TIME_W(TIME_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
      .mine_map(mine_map), .revealed(revealed), .flagged(flagged),
      .reveal_count(reveal_count), .flag_count(flag_count), .seconds(seconds),
      .placing(placing), .endgame(endgame), .win(win)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // Hard stop in case the run never reaches its summary line.
   initial begin
      #900000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge. Outputs are sampled 1 unit after it.
   // Play time accrues on edges that begin while the game is live.
   task automatic tick();
      bit wasPlaying;
      wasPlaying = mPlaying;
      @(posedge clk);
      #1;
      if (wasPlaying) playEdges++;
   endtask

   function automatic int expSeconds();
      int s;
      s = playEdges / CLK_HZ;
      return (s > (1 << TIME_W) - 1) ? (1 << TIME_W) - 1 : s;
   endfunction

   function automatic int lfsrStep(input int l);
      int b;
      b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
      return (l >> 1) | (b << 15);
   endfunction

   // Draw candidates from the seeded LFSR until MINES distinct legal cells are chosen.
   // Returns the number of candidates consumed, which is one per placement cycle.
   function automatic int placeModel(input logic [15:0] sd, input int excl, output logic [63:0] map);
      int l, placed, cyc, c;
      l = (sd == 16'h0000) ? 'hACE1 : int'(sd);
      placed = 0;
      cyc = 0;
      map = '0;
      while (placed < MINES && cyc < 100000) begin
         c = l % (1 << $clog2(N));
         cyc++;
         if (c < N && !map[c] && c != excl) begin
            map[c] = 1'b1;
            placed++;
         end
         l = lfsrStep(l);
      end
      return cyc;
   endfunction

   task automatic applyModel(input bit op, input int idx);
      if (idx >= N) return;
      if (!op) begin
         if (!mFlag[idx] && !mRev[idx]) begin
            mRev[idx] = 1'b1;
            if (mMine[idx]) begin
               mLost = 1'b1;
               mPlaying = 1'b0;
            end else begin
               mRevCnt++;
               if (mRevCnt == N - MINES) begin
                  mWon = 1'b1;
                  mPlaying = 1'b0;
               end
            end
         end
      end else if (!mRev[idx]) begin
         mFlag[idx] = ~mFlag[idx];
         mFlagCnt += mFlag[idx] ? 1 : -1;
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".mine_map"}, mine_map, mMine);
      checkOutput({tag, ".revealed"}, revealed, mRev);
      checkOutput({tag, ".flagged"}, flagged, mFlag);
      checkOutput({tag, ".reveal_count"}, 64'(reveal_count), 64'(mRevCnt));
      checkOutput({tag, ".flag_count"}, 64'(flag_count), 64'(mFlagCnt));
      checkOutput({tag, ".seconds"}, 64'(seconds), 64'(expSeconds()));
      checkOutput({tag, ".endgame"}, 64'(endgame), 64'(mLost | mWon));
      checkOutput({tag, ".win"}, 64'(win), 64'(mWon));
      checkOutput({tag, ".cmd_ready"}, 64'(cmd_ready), 64'(mPlaying));
   endtask

   task automatic clearModel();
      mMine = '0; mRev = '0; mFlag = '0;
      mRevCnt = 0; mFlagCnt = 0; playEdges = 0;
      mPlaying = 1'b0; mLost = 1'b0; mWon = 1'b0;
   endtask

   // Drives one command for one cycle and checks the whole visible state afterwards.
   task automatic applyStimulus(input bit op, input int idx, input string tag);
      bit acc;
      acc = mPlaying;
      checkOutput({tag, ".ready_pre"}, 64'(cmd_ready), 64'(acc));
      cmd_valid = 1'b1; cmd_op = op; cmd_idx = 6'(idx);
      tick();
      cmd_valid = 1'b0;
      if (acc) applyModel(op, idx);
      checkAll(tag);
   endtask

   // Pulses start, optionally with a colliding command, then runs placement to completion.
   // With first-click-safe builds the arming reveal goes to armCell.
   task automatic startGame(input logic [15:0] sd, input int armCell, input bit withCmd);
      int expCyc, n, excl;
      seed = sd; start = 1'b1;
      cmd_valid = withCmd; cmd_op = 1'b0; cmd_idx = 6'(armCell);
      tick();
      start = 1'b0; cmd_valid = 1'b0;
      clearModel();
      checkOutput("start.revealed", revealed, 64'h0);
      checkOutput("start.mine_map", mine_map, 64'h0);
      checkOutput("start.seconds", 64'(seconds), 64'h0);
      checkOutput("start.counts", 64'({reveal_count, flag_count}), 64'h0);
      excl = -1;
`ifdef FIRST_CLICK_SAFE_EN
      checkOutput("armed.placing", 64'(placing), 64'h0);
      checkOutput("armed.ready", 64'(cmd_ready), 64'h1);
      cmd_valid = 1'b1; cmd_op = 1'b1; cmd_idx = 6'(armCell);
      tick();
      checkOutput("armed.flag_ignored", 64'(placing), 64'h0);
      cmd_op = 1'b0;
      tick();
      cmd_valid = 1'b0;
      excl = armCell;
`endif
      checkOutput("place.placing", 64'(placing), 64'h1);
      expCyc = placeModel(sd, excl, mMine);
      n = 0;
      while (placing === 1'b1 && n < 64 * MINES) begin
         tick();
         n++;
      end
      checkOutput("place.cycles", 64'(n), 64'(expCyc));
      checkOutput("place.popcount", 64'($countones(mine_map)), 64'(MINES));
      mPlaying = 1'b1;
`ifdef FIRST_CLICK_SAFE_EN
      mRev[armCell] = 1'b1;
      mRevCnt = 1;
`endif
      checkAll("place.done");
   endtask

   // Starts a game and leaves it part-way through placement.
   task automatic beginPlace(input logic [15:0] sd);
      seed = sd; start = 1'b1;
      tick();
      start = 1'b0;
      clearModel();
`ifdef FIRST_CLICK_SAFE_EN
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_idx = 6'd3;
      tick();
      cmd_valid = 1'b0;
`endif
      repeat (3) tick();
      checkOutput("midplace.placing", 64'(placing), 64'h1);
   endtask

   initial begin
      int s, m;
      rst = 1'b1; start = 1'b0; seed = 16'h0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_idx = '0;
      clearModel();
      tick(); tick();
      rst = 1'b0;
      repeat (10) tick();
      checkAll("reset");
      checkOutput("reset.placing", 64'(placing), 64'h0);

      // Game A: flag handling, then reveal every safe cell for a win.
      startGame(16'h1234, 0, 1'b0);
      applyStimulus(1'b1, 5, "flag5.set");
      checkOutput("flag5.cnt_a", 64'(flag_count), 64'd1);
      applyStimulus(1'b0, 5, "flag5.reveal");
      checkOutput("flag5.rev_blocked", 64'(revealed[5]), 64'h0);
      checkOutput("flag5.cnt_b", 64'(flag_count), 64'd1);
      applyStimulus(1'b1, 5, "flag5.clear");
      checkOutput("flag5.cnt_c", 64'(flag_count), 64'd0);
      applyStimulus(1'b1, 5, "flag5.again");
      checkOutput("flag5.cnt_d", 64'(flag_count), 64'd1);
      applyStimulus(1'b1, 5, "flag5.off");
      s = 1;
      while (mMine[s]) s++;
      applyStimulus(1'b0, s, "safe.reveal");
      applyStimulus(1'b1, s, "flag.on_revealed");
      for (int i = 0; i < N; i++) begin
         if (!mMine[i]) begin
            repeat ($urandom_range(0, 2)) tick();
            applyStimulus(1'b0, i, "winrun");
         end
      end
      checkOutput("win.endgame", 64'(endgame), 64'h1);
      checkOutput("win.win", 64'(win), 64'h1);
      checkOutput("win.reveal_count", 64'(reveal_count), 64'(N - MINES));
      checkOutput("win.seconds_sat", 64'(seconds), 64'd7);
      applyStimulus(1'b0, 0, "won.cmd_blocked");

      // Game B: start collides with a command; seed 0 maps to the default LFSR value.
      startGame(16'h5A5A, 9, 1'b0);
      startGame(16'h0000, 9, 1'b1);
      repeat (40) tick();
      checkAll("timer.idle40");
      checkOutput("timer.saturated", 64'(seconds), 64'd7);
      m = 0;
      while (!mMine[m]) m++;
      applyStimulus(1'b0, m, "lose.reveal_mine");
      checkOutput("lose.endgame", 64'(endgame), 64'h1);
      checkOutput("lose.win", 64'(win), 64'h0);
      repeat (6) tick();
      checkAll("lose.hold");

      // Restart during placement, and reset during placement.
      beginPlace(16'hC0DE);
      startGame(16'h7777, 12, 1'b0);
      beginPlace(16'h4321);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clearModel();
      checkAll("rst.midplace");
      checkOutput("rst.placing", 64'(placing), 64'h0);

      // Randomised games with mixed commands and gaps.
      for (int g = 0; g < 4; g++) begin
         startGame(16'($urandom), $urandom_range(0, N - 1), 1'b0);
         for (int st = 0; st < 70 && mPlaying; st++) begin
            repeat ($urandom_range(0, 1)) tick();
            applyStimulus(($urandom_range(0, 3) == 0), $urandom_range(0, N - 1), "rand");
         end
      end

`ifdef FIRST_CLICK_SAFE_EN
      for (int sd = 1; sd <= 50; sd++) begin
         startGame(16'(sd), 0, 1'b0);
         checkOutput("fcs.mine0", 64'(mine_map[0]), 64'h0);
         checkOutput("fcs.rev0", 64'(revealed[0]), 64'h1);
         checkOutput("fcs.count", 64'(reveal_count), 64'd1);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mine_game_ctrl.md
# mine_game_ctrl

Parametrised game controller for the minesweeper design. It generalises the fixed 8x8, hard-coded-map controller to a ROWS x COLS board. Mines are placed at run time from an LFSR seed. The block owns the mine, revealed and flagged bitmaps, and accepts reveal/flag commands over a valid/ready handshake. It also tracks the reveal count, flag count and elapsed seconds, and produces endgame/win for the renderer and the top-level display logic.

## Interface
- ROWS, 8, board rows (2..32)
- COLS, 8, board columns (2..32)
- MINES, 10, mine count; must satisfy 1 <= MINES <= ROWS*COLS-2; elaboration fails otherwise
- CLK_HZ, 25000000, clock cycles per second for the timer
- TIME_W, 10, width of the seconds counter

Derived values: N = ROWS*COLS, IW = $clog2(N), CW = $clog2(N+1).

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a new game from any state
- seed  in  16  LFSR seed, sampled on start; 0 is replaced by 16'hACE1
- cmd_valid  in  1  command present
- cmd_ready  out  1  command can be accepted this cycle
- cmd_op  in  1  0 = reveal, 1 = toggle flag
- cmd_idx  in  IW  cell index, row*COLS+col; values >= N are accepted and ignored
- mine_map  out  N  1 = mine
- revealed  out  N  1 = revealed
- flagged  out  N  1 = flagged
- reveal_count  out  CW  number of safe cells revealed
- flag_count  out  CW  number of flags currently set
- seconds  out  TIME_W  elapsed game time
- placing  out  1  high while mines are being placed
- endgame  out  1  game over
- win  out  1  game won; valid only while endgame is high

## Operation
- States: IDLE, ARMED, PLACE, PLAYING, LOST, WON.
- Reset puts the block in IDLE. All outputs are 0, all bitmaps clear, and the LFSR is loaded with 16'hACE1.
- start in any state:
  - Clears all bitmaps and counters.
  - Loads the LFSR from seed.
  - Goes to ARMED (see Configuration) or PLACE.
- PLACE sequence, one candidate per cycle:
  - The LFSR (x^16+x^14+x^13+x^11+1, Fibonacci) steps every cycle.
  - Candidate = lfsr[IW-1:0].
  - The candidate is rejected if >= N, if it is already a mine, or if it equals the excluded cell.
  - Otherwise the candidate's mine_map bit is set and the placed count is incremented.
  - When the placed count reaches MINES, go to PLAYING.
- cmd_ready is 1 in ARMED and PLAYING, and 0 in all other states. A command is accepted on a cycle where cmd_valid && cmd_ready.
- Reveal command in PLAYING:
  - Flagged or already-revealed cell: no effect.
  - Mine cell: set its revealed bit and go to LOST.
  - Safe cell: set its revealed bit and increment reveal_count. If the new count equals N-MINES, go to WON.
- Flag command in PLAYING:
  - Revealed cell: no effect.
  - Otherwise toggle the flagged bit and adjust flag_count by +1 or -1.
  - No cap on flag count; at most N.
- Timer:
  - A prescaler counts to CLK_HZ-1 while in PLAYING, then increments seconds.
  - seconds saturates at all-ones.
  - Prescaler and seconds are held (not cleared) in LOST and WON; both are cleared on start.
- LOST: endgame=1, win=0.
- WON: endgame=1, win=1.
- LOST and WON are terminal until start or rst.
- No flood fill: each reveal uncovers exactly one cell. Area expansion belongs to a separate block.

## Timing
- Outputs are registered. Bitmap, count and state updates appear on the clock edge after command acceptance.
- endgame/win assert on the same edge as the final reveal bit.
- PLACE lasts at least MINES cycles. The duration is seed-dependent; the bench bounds it at 64*MINES cycles.
- placing is high from the edge after start (or after the arming reveal) until the edge where PLAYING is entered.
- Simultaneous start and cmd_valid: start wins and the command is dropped.
- rst overrides start.
- rst mid-placement returns to IDLE with all bitmaps clear on the next edge.

## Configuration
- FIRST_CLICK_SAFE_EN defined:
  - start goes to ARMED.
  - Only a reveal is accepted in ARMED; flag commands in ARMED are accepted and ignored.
  - The reveal's cell becomes the excluded cell, and the block goes to PLACE.
  - After placement, the block applies that pending reveal in the PLAYING entry cycle. The first reveal therefore never hits a mine.
- FIRST_CLICK_SAFE_EN undefined:
  - start goes straight to PLACE.
  - ARMED is unreachable and there is no excluded cell.

## Test plan
- Reset, then idle for 10 cycles -> every output 0, cmd_ready=0.
- ROWS=COLS=8, MINES=10, start with seed=16'h1234 -> placing falls within 640 cycles, popcount(mine_map)=10, state is PLAYING.
- Reveal every non-mine index in order -> reveal_count steps 1..54; endgame=1 and win=1 on the edge after the 54th accept; cmd_ready=0 afterwards.
- Flag cell 5, reveal cell 5, unflag, flag again -> flag_count goes 1,1,0,1; revealed[5] stays 0 while flagged; a later reveal of a mine cell gives endgame=1, win=0.
- CLK_HZ=4, TIME_W=3: play for 40 cycles -> seconds saturates at 7. Then start -> seconds=0.
- With FIRST_CLICK_SAFE_EN: for seeds 1..50, first reveal at cell 0 -> mine_map[0]=0, revealed[0]=1, reveal_count=1 after placement. Start asserted during PLACE restarts placement cleanly.
